// File: rtl/porta_bus_pkg.sv
// porta_bus_pkg
//   Shared definitions for the Z80 bus master: FSM state encoding, timing
//   defaults, timer width, the latched command record and a small helper
//   that tells whether a state drives the bus.
package porta_bus_pkg;

  localparam int TIMER_W           = 8;
  localparam int STROBE_CYCLES_DEF = 3;
  localparam int BUSAK_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RELEASE = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

  typedef struct packed {
    logic        write;
    logic        io;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  // States in which we own the bus and drive A / strobes.
  function automatic logic on_bus(state_t s);
    return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/porta_cycle_timer.sv
// porta_cycle_timer
//   8-bit loadable down-counter that sticks at zero. Shared between the
//   BUSAKn wait timeout and the strobe width.
//   clk, RESETn : clock, synchronous active-low reset
//   load        : load load_val this edge (takes priority over counting)
//   load_val    : reload value
//   count       : current value
//   zero        : count == 0
module porta_cycle_timer import porta_bus_pkg::*; (
  input  logic               clk,
  input  logic               RESETn,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  always_ff @(posedge clk) begin
    if (!RESETn)             count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/porta_bus_master.sv
// porta_bus_master
//   Takes one read/write command at a time, requests the Z80 bus with
//   BUSRQn, runs a single memory or I/O cycle once BUSAKn grants it, then
//   hands the bus back and returns a response.
//   cmd_*   : command handshake (write, io, addr, wdata)
//   rsp_*   : response handshake (rdata, error = no grant / grant lost)
//   BUSRQn / BUSAKn : Z80 bus request / acknowledge, active-low
//   bus_oe  : enables external tristates for A and the strobes
//   A_out, D_out, D_oe, D_in : address, data out, data-out enable, data in
//   MREQn_out, IORQn_out, RDn_out, WRn_out : bus strobes, active-low
//   busy    : not idle
module porta_bus_master import porta_bus_pkg::*; #(
  parameter int STROBE_CYCLES = STROBE_CYCLES_DEF,
  parameter int BUSAK_TIMEOUT = BUSAK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        RESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_io,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        BUSRQn,
  input  logic        BUSAKn,
  output logic        bus_oe,
  output logic [15:0] A_out,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        MREQn_out,
  output logic        IORQn_out,
  output logic        RDn_out,
  output logic        WRn_out,
  output logic        busy
);

  state_t             state, nxt;
  cmd_t               cmd_q;
  logic               handshake;
  logic               err_set;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic [TIMER_W-1:0] timer_cnt;
  logic               timer_zero;

  assign handshake = cmd_valid && cmd_ready && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign A_out     = cmd_q.addr;
  assign D_out     = cmd_q.wdata;

  // Timer holds "cycles left after this one"; it is reloaded whenever the
  // state changes, so zero marks the last cycle of REQ or STROBE.
  porta_cycle_timer u_timer (
    .clk      (clk),
    .RESETn   (RESETn),
    .load     (timer_load),
    .load_val (timer_val),
    .count    (timer_cnt),
    .zero     (timer_zero)
  );

  always_comb begin
    nxt        = state;
    err_set    = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      ST_IDLE:    if (handshake) nxt = ST_REQ;
      ST_REQ: begin
        if (!BUSAKn) nxt = ST_SETUP;
        else if (timer_zero) begin
          nxt     = ST_RELEASE;
          err_set = 1'b1;
        end
      end
      ST_SETUP:   nxt = ST_STROBE;
      ST_STROBE:  if (timer_zero) nxt = ST_HOLD;
      ST_HOLD:    nxt = ST_RELEASE;
      ST_RELEASE: nxt = ST_RESP;
      // Waiting for BUSAKn high keeps a new request off the old grant.
      ST_RESP:    if (rsp_ready && BUSAKn) nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
    // Grant dropped while we own the bus: get off it right away.
    if (on_bus(state) && BUSAKn) begin
      nxt     = ST_RELEASE;
      err_set = 1'b1;
    end
    if (nxt != state) begin
      timer_load = 1'b1;
      case (nxt)
        ST_REQ:    timer_val = TIMER_W'(BUSAK_TIMEOUT - 1);
        ST_STROBE: timer_val = TIMER_W'(STROBE_CYCLES - 1);
        default:   timer_val = '0;
      endcase
    end
  end

  // Bus-side outputs are decoded from the next state and registered, so
  // they change only on clk edges and line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      BUSRQn    <= 1'b1;
      bus_oe    <= 1'b0;
      D_oe      <= 1'b0;
      MREQn_out <= 1'b1;
      IORQn_out <= 1'b1;
      RDn_out   <= 1'b1;
      WRn_out   <= 1'b1;
    end else begin
      state     <= nxt;
      cmd_ready <= (nxt == ST_IDLE);
      rsp_valid <= (nxt == ST_RESP);
      BUSRQn    <= !((nxt == ST_REQ) || on_bus(nxt));
      bus_oe    <= on_bus(nxt);
      D_oe      <= on_bus(nxt) && cmd_q.write;
      MREQn_out <= !((nxt == ST_STROBE) && !cmd_q.io);
      IORQn_out <= !((nxt == ST_STROBE) &&  cmd_q.io);
      RDn_out   <= !((nxt == ST_STROBE) && !cmd_q.write);
      WRn_out   <= !((nxt == ST_STROBE) &&  cmd_q.write);

      if (handshake) begin
        cmd_q     <= '{write: cmd_write, io: cmd_io, addr: cmd_addr, wdata: cmd_wdata};
        rsp_rdata <= '0;
        rsp_error <= 1'b0;
      end

      if (err_set) begin
        rsp_error <= 1'b1;
        rsp_rdata <= '0;
      end else if ((state == ST_STROBE) && timer_zero && !cmd_q.write) begin
        rsp_rdata <= D_in;
      end
    end
  end

endmodule

// File: tb/tb_porta_bus_master.sv
// tb_porta_bus_master
//   Directed and randomized transactions against a cycle-count model of the
//   bus master, with a small Z80 bus-arbiter model answering BUSRQn.
module tb_porta_bus_master;

  localparam int SC = 3;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        RESETn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_io;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [7:0]  rsp_rdata;
  logic        BUSRQn, BUSAKn, bus_oe, D_oe, busy;
  logic [15:0] A_out;
  logic [7:0]  D_out, D_in;
  logic        MREQn_out, IORQn_out, RDn_out, WRn_out;

  int vectors     = 0;
  int miscompares = 0;

  // Z80 arbiter model state
  int g_dly    = 1;   // grant this many cycles after BUSRQn falls; 0 = never
  bit lost     = 0;   // grant withdrawn until BUSRQn goes high
  bit z80_hold = 0;   // keep BUSAKn low after BUSRQn goes high
  int rq_cnt   = 0;

  always #5 clk = ~clk;

  porta_bus_master dut (
    .clk(clk), .RESETn(RESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_io(cmd_io), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .BUSRQn(BUSRQn), .BUSAKn(BUSAKn), .bus_oe(bus_oe),
    .A_out(A_out), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .MREQn_out(MREQn_out), .IORQn_out(IORQn_out), .RDn_out(RDn_out),
    .WRn_out(WRn_out), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample point is the falling edge, where the arbiter reacts.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (!BUSRQn) begin
      rq_cnt++;
      if (lost) BUSAKn = 1'b1;
      else if (g_dly != 0 && rq_cnt >= g_dly) BUSAKn = 1'b0;
    end else begin
      rq_cnt = 0;
      lost   = 0;
      if (!z80_hold) BUSAKn = 1'b1;
    end
  endtask

  // g: grant delay (0 = never); lose_k: drop grant in strobe cycle k;
  // rst_k: reset in strobe cycle k; rdy_wait: cycles rsp_ready held low;
  // hold_n: cycles rsp_ready high while BUSAKn still low.
  task automatic do_txn(input bit wr, input bit io, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] din, input int g,
                        input int lose_k, input int rst_k, input int rdy_wait,
                        input int hold_n);
    int lat = 0, rq_low = 0, boe_n = 0, mq = 0, iq = 0, rdc = 0, wrc = 0, sc_seen = 0;
    int exp_lat, exp_sc, exp_boe;
    bit exp_err, bad_drv = 0, bad_wait = 0, strobe;
    logic [7:0] hold_rd;
    logic       hold_er;

    // Reference: cycle budget per phase REQ(g) SETUP(1) STROBE(SC) HOLD(1) RELEASE(1)
    if (g == 0 || g > TO) begin
      exp_lat = TO + 1; exp_err = 1; exp_sc = 0; exp_boe = 0;
    end else if (lose_k > 0) begin
      exp_lat = g + 1 + lose_k + 1; exp_err = 1; exp_sc = lose_k; exp_boe = 1 + lose_k;
    end else begin
      exp_lat = g + 1 + SC + 1 + 1; exp_err = 0; exp_sc = SC; exp_boe = SC + 2;
    end

    g_dly    = g;
    z80_hold = (hold_n > 0);
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_write = wr; cmd_io = io; cmd_addr = addr; cmd_wdata = wd;
    cmd_valid = 1'b1;
    D_in = ~din;
    cyc();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_io = 1'($urandom);
    cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom);
    chk("busy_after_hs", {30'd0, busy, cmd_ready}, 2'b10);

    while (!rsp_valid && lat < 400) begin
      if (!BUSRQn) rq_low++;
      if (bus_oe) begin
        boe_n++;
        if (A_out !== addr || D_oe !== wr || (wr && D_out !== wd)) bad_drv = 1;
      end else if (D_oe !== 1'b0 || {MREQn_out, IORQn_out, RDn_out, WRn_out} !== 4'hF) begin
        bad_drv = 1;
      end
      if (!MREQn_out) mq++;
      if (!IORQn_out) iq++;
      if (!RDn_out)   rdc++;
      if (!WRn_out)   wrc++;
      strobe = !(MREQn_out && IORQn_out);
      if (strobe) sc_seen++;
      // Valid data only in the last strobe cycle, so late/early capture shows.
      D_in = (strobe && sc_seen == SC) ? din : ~din;
      if (strobe && lose_k > 0 && sc_seen == lose_k) begin
        lost = 1; BUSAKn = 1'b1;
      end
      if (strobe && rst_k > 0 && sc_seen == rst_k) begin
        RESETn = 1'b0;
        cyc();
        chk("rst_mid_strobes", {28'd0, MREQn_out, IORQn_out, RDn_out, WRn_out}, 4'hF);
        chk("rst_mid_bus", {29'd0, bus_oe, D_oe, BUSRQn}, 3'b001);
        chk("rst_mid_rsp", {29'd0, rsp_valid, busy, cmd_ready}, 3'b000);
        RESETn = 1'b1;
        cyc();
        chk("rst_mid_ready", 32'(cmd_ready), 1);
        return;
      end
      cyc();
      lat++;
    end

    chk("latency", lat, exp_lat);
    chk("rsp_error", 32'(rsp_error), 32'(exp_err));
    if (!wr || exp_err) chk("rsp_rdata", 32'(rsp_rdata), exp_err ? 32'd0 : 32'(din));
    chk("busrq_low_cycles", rq_low, exp_lat - 1);
    chk("bus_oe_cycles", boe_n, exp_boe);
    chk("mreq_cycles", mq, io ? 0 : exp_sc);
    chk("iorq_cycles", iq, io ? exp_sc : 0);
    chk("rd_cycles", rdc, wr ? 0 : exp_sc);
    chk("wr_cycles", wrc, wr ? exp_sc : 0);
    chk("bus_drive", 32'(bad_drv), 0);

    // Response hold: a new command is offered but must not be taken.
    hold_rd = rsp_rdata; hold_er = rsp_error;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < rdy_wait; i++) begin
      cyc();
      if (!rsp_valid || cmd_ready || !busy || rsp_rdata !== hold_rd || rsp_error !== hold_er)
        bad_wait = 1;
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < hold_n; i++) begin
      cyc();
      if (!rsp_valid || cmd_ready || !busy || rsp_rdata !== hold_rd) bad_wait = 1;
    end
    z80_hold = 0;
    BUSAKn   = 1'b1;
    cyc();
    chk("resp_hold", 32'(bad_wait), 0);
    chk("resp_exit", {29'd0, rsp_valid, busy, cmd_ready}, 3'b001);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    bit r_wr, r_io;
    int r_lose;
    RESETn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_io = 0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0; BUSAKn = 1'b1; D_in = '0;
    repeat (2) cyc();
    chk("rst_strobes", {27'd0, MREQn_out, IORQn_out, RDn_out, WRn_out, BUSRQn}, 5'h1F);
    chk("rst_oe", {30'd0, bus_oe, D_oe}, 0);
    chk("rst_addr", 32'(A_out), 0);
    chk("rst_dout", 32'(D_out), 0);
    chk("rst_rsp", {22'd0, rsp_valid, rsp_error, rsp_rdata}, 0);
    chk("rst_ready_busy", {30'd0, cmd_ready, busy}, 0);
    RESETn = 1'b1;
    cyc();
    chk("ready_after_rst", 32'(cmd_ready), 1);

    do_txn(0, 0, 16'h6000, 8'h00, 8'hA5, 2, 0, 0, 0, 0);  // memory read
    do_txn(1, 1, 16'h00FF, 8'h3C, 8'h00, 1, 0, 0, 0, 0);  // I/O write, immediate grant
    do_txn(0, 0, 16'h1234, 8'h00, 8'h77, 0, 0, 0, 1, 0);  // no grant -> timeout
    do_txn(0, 1, 16'h0042, 8'h00, 8'h5A, 2, 2, 0, 0, 0);  // grant lost mid-strobe
    do_txn(1, 0, 16'h8000, 8'h11, 8'h00, 1, 0, 2, 0, 0);  // reset mid-strobe
    do_txn(0, 0, 16'hBEEF, 8'h00, 8'hC3, 3, 0, 0, 0, 0);  // normal after reset
    do_txn(0, 0, 16'h4000, 8'h00, 8'h99, 1, 0, 0, 10, 3); // slow rsp_ready, late BUSAKn
    do_txn(0, 1, 16'h0010, 8'h00, 8'h3E, 1, SC, 0, 0, 0); // grant lost in last strobe cycle

    for (int n = 0; n < 24; n++) begin
      r_wr   = 1'($urandom);
      r_io   = 1'($urandom);
      r_lose = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SC)) : 0;
      do_txn(r_wr, r_io, 16'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(1, 6)), r_lose, 0,
             int'($urandom_range(0, 3)), r_lose == 0 ? int'($urandom_range(0, 2)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
